// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the multi-channel clock divider.
//   DEF_DIV_C : default divisor loaded into every channel at reset
//   cnt_t     : counter / divisor / high-time word (CNT_W_C bits)
//   ch_cfg_t  : one channel configuration request (divisor + high-time)
//   eff_div() : effective divisor; divisors below 2 behave as 2
// Modules built with a CNT_W parameter must keep CNT_W <= CNT_W_C, because
// they widen their values to cnt_t before calling eff_div().
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int CNT_W_C   = 28;
    localparam int DEF_DIV_C = 50_000_000;

    typedef logic [CNT_W_C-1:0] cnt_t;

    typedef struct packed {
        cnt_t div;
        cnt_t high;
    } ch_cfg_t;

    // A divisor of 0 or 1 cannot produce a square wave, so both run as 2.
    function automatic cnt_t eff_div(input cnt_t div);
        return (div < cnt_t'(2)) ? cnt_t'(2) : div;
    endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// -----------------------------------------------------------------------------
// clkdiv_channel
// One divider channel: period counter, active and shadow divisor/high-time,
// pending flag and registered output.
// Ports:
//   i_clk, i_rst_n  : clock and asynchronous active-low reset
//   i_en            : run enable; while low the counter sits at 0, output low
//   i_sync          : restart at phase 0 (ignored while disabled)
//   i_wr            : config write strobe (only honoured when not pending)
//   i_div, i_high   : config values written into the shadow registers
//   o_clk           : divided output (registered)
//   o_pending       : shadow config waiting for the period boundary
//   o_tick          : one-cycle pulse on wrap / sync restart
//                     (present only when CLKDIV_TICK_EN is defined)
// -----------------------------------------------------------------------------
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = 28,
    parameter int DEF_DIV = 50_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_high,
`ifdef CLKDIV_TICK_EN
    output logic             o_tick,
`endif
    output logic             o_clk,
    output logic             o_pending
);

    localparam logic [CNT_W-1:0] DEF_DIV_V  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH_V = CNT_W'(DEF_DIV / 2);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_high_act;
    logic [CNT_W-1:0] r_div_sh;
    logic [CNT_W-1:0] r_high_sh;
    logic             r_pending;
    logic             r_out;

    cnt_t             w_eff_full;
    logic [CNT_W-1:0] w_eff_div;
    logic [CNT_W-1:0] w_eff_m1;
    logic [CNT_W-1:0] w_high_new;
    logic             w_wrap;
    logic             w_accept;
    logic             w_apply;

    assign w_eff_full = eff_div(cnt_t'(r_div_act));
    assign w_eff_div  = w_eff_full[CNT_W-1:0];
    assign w_eff_m1   = w_eff_div - CNT_W'(1);
    assign w_wrap     = (r_cnt >= w_eff_m1);

    // A write and an apply can never coincide: writes are only accepted
    // while nothing is pending, and apply requires something pending. A
    // write on the wrap cycle therefore waits for the following wrap.
    assign w_accept   = i_wr && !r_pending;
    assign w_apply    = r_pending && (!i_en || i_sync || w_wrap);

    // On sync the shadow takes effect on the same edge, so the phase-0
    // output must already use the new high-time.
    assign w_high_new = r_pending ? r_high_sh : r_high_act;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_div_act  <= DEF_DIV_V;
            r_high_act <= DEF_HIGH_V;
            r_div_sh   <= DEF_DIV_V;
            r_high_sh  <= DEF_HIGH_V;
            r_pending  <= 1'b0;
            r_out      <= 1'b0;
        end else begin
            if (!i_en) begin
                r_cnt <= '0;
                r_out <= 1'b0;
            end else if (i_sync) begin
                r_cnt <= '0;
                r_out <= (w_high_new != '0);
            end else begin
                r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                // Compared against the pre-update count: one cycle of
                // latency from counter to pin.
                r_out <= (r_cnt < r_high_act);
            end

            if (w_apply) begin
                r_div_act  <= r_div_sh;
                r_high_act <= r_high_sh;
            end

            if (w_accept) begin
                r_div_sh  <= i_div;
                r_high_sh <= i_high;
            end

            if (w_accept) begin
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_TICK_EN
    logic r_tick;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= i_en && (i_sync || w_wrap);
        end
    end

    assign o_tick = r_tick;
`endif

    assign o_clk     = r_out;
    assign o_pending = r_pending;

endmodule

// File: rtl/clock_divider_multi.sv
// -----------------------------------------------------------------------------
// clock_divider_multi
// NUM_CH runtime-programmable square-wave dividers running from clock_in.
// Configuration arrives over a valid/ready port and is applied at the
// target channel's period boundary (or immediately on sync / while disabled).
// Ports:
//   clock_in     : fabric clock, rising edge
//   reset_n      : asynchronous active-low reset
//   ch_en        : per-channel run enable
//   sync         : restart all enabled channels at phase 0
//   cfg_valid    : config request valid
//   cfg_ready    : request can be accepted (combinational)
//   cfg_ch       : target channel; indices >= NUM_CH are accepted and dropped
//   cfg_div      : new divisor in clock_in cycles
//   cfg_high     : new high-time in clock_in cycles
//   clock_out    : divided outputs, registered
//   cfg_pending  : per-channel shadow config waiting for the boundary
//   tick         : per-channel wrap/sync pulse, only with CLKDIV_TICK_EN
// Optional feature macro: CLKDIV_TICK_EN
// -----------------------------------------------------------------------------
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 28,
    parameter int DEF_DIV = DEF_DIV_C,
    parameter int CH_W    = 2
) (
    input  logic              clock_in,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
`ifdef CLKDIV_TICK_EN
    output logic [NUM_CH-1:0] tick,
`endif
    output logic [NUM_CH-1:0] clock_out,
    output logic [NUM_CH-1:0] cfg_pending
);

    ch_cfg_t           w_req;
    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_wr;
    logic [NUM_CH-1:0] w_clk;
    logic              w_ready;

    assign w_req.div  = cnt_t'(cfg_div);
    assign w_req.high = cnt_t'(cfg_high);

    // Out-of-range channel indices never match, so they see ready=1 and
    // their transfer lands nowhere.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                w_ready = !w_pending[i];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_wr[gi] = cfg_valid && w_ready && (cfg_ch == CH_W'(gi));

            clkdiv_channel #(
                .CNT_W   (CNT_W),
                .DEF_DIV (DEF_DIV)
            ) u_ch (
                .i_clk     (clock_in),
                .i_rst_n   (reset_n),
                .i_en      (ch_en[gi]),
                .i_sync    (sync),
                .i_wr      (w_wr[gi]),
                .i_div     (w_req.div[CNT_W-1:0]),
                .i_high    (w_req.high[CNT_W-1:0]),
`ifdef CLKDIV_TICK_EN
                .o_tick    (tick[gi]),
`endif
                .o_clk     (w_clk[gi]),
                .o_pending (w_pending[gi])
            );
        end
    endgenerate

    assign cfg_ready   = w_ready;
    assign clock_out   = w_clk;
    assign cfg_pending = w_pending;

endmodule

// File: tb/tb_clock_divider_multi.sv
// -----------------------------------------------------------------------------
// tb_clock_divider_multi
// Self-checking bench for clock_divider_multi (NUM_CH=4, DEF_DIV=10, CH_W=3).
// The reference model tracks, per channel, the edge at which the current
// period began plus the period/high-time in force and any queued config;
// the expected output is simply "edges since period start < high-time".
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_divider_multi;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 28;
    localparam int DEF_DIV = 10;
    localparam int CH_W    = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NUM_CH-1:0] ch_en = '0;
    logic              sync = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [CNT_W-1:0]  cfg_div = '0;
    logic [CNT_W-1:0]  cfg_high = '0;
    logic [NUM_CH-1:0] clock_out;
    logic [NUM_CH-1:0] cfg_pending;
`ifdef CLKDIV_TICK_EN
    logic [NUM_CH-1:0] tick;
`endif

    always #5 clk = ~clk;

    clock_divider_multi #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV),
        .CH_W    (CH_W)
    ) dut (
        .clock_in    (clk),
        .reset_n     (rst_n),
        .ch_en       (ch_en),
        .sync        (sync),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_high    (cfg_high),
`ifdef CLKDIV_TICK_EN
        .tick        (tick),
`endif
        .clock_out   (clock_out),
        .cfg_pending (cfg_pending)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    int ecount = 0;               // number of clock edges modelled so far
    int m_start [NUM_CH];         // edge index at which current period began
    int m_div   [NUM_CH];
    int m_high  [NUM_CH];
    int m_sdiv  [NUM_CH];
    int m_shigh [NUM_CH];
    bit m_pend  [NUM_CH];
    bit m_out   [NUM_CH];
    bit m_tick  [NUM_CH];
    bit ready_exp;
    logic ready_seen;

    function automatic int period_of(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic logic [NUM_CH-1:0] out_vec();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_out[i];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] pend_vec();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] tick_vec();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = m_tick[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_start[i] = ecount;
            m_div[i]   = DEF_DIV;
            m_high[i]  = DEF_DIV / 2;
            m_sdiv[i]  = DEF_DIV;
            m_shigh[i] = DEF_DIV / 2;
            m_pend[i]  = 1'b0;
            m_out[i]   = 1'b0;
            m_tick[i]  = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass and advance the
    // model by that edge. Returns 1 ns after the edge.
    task automatic step(input logic [NUM_CH-1:0] en, input logic s,
                        input logic v, input int ch, input int d, input int h);
        int  elapsed;
        bit  apply;
        ch_en     = en;
        sync      = s;
        cfg_valid = v;
        cfg_ch    = CH_W'(ch);
        cfg_div   = CNT_W'(d);
        cfg_high  = CNT_W'(h);
        #1;
        ready_exp  = (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
        ready_seen = cfg_ready;
        @(posedge clk);
        for (int i = 0; i < NUM_CH; i++) begin
            elapsed = ecount - m_start[i];
            apply   = 1'b0;
            if (!en[i]) begin
                m_out[i]   = 1'b0;
                m_tick[i]  = 1'b0;
                m_start[i] = ecount + 1;
                apply      = m_pend[i];
            end else if (s) begin
                apply      = m_pend[i];
                m_out[i]   = ((apply ? m_shigh[i] : m_high[i]) > 0);
                m_tick[i]  = 1'b1;
                m_start[i] = ecount + 1;
            end else begin
                m_out[i]  = (elapsed < m_high[i]);
                m_tick[i] = (elapsed + 1 >= period_of(m_div[i]));
                if (m_tick[i]) begin
                    m_start[i] = ecount + 1;
                    apply      = m_pend[i];
                end
            end
            if (apply) begin
                m_div[i]  = m_sdiv[i];
                m_high[i] = m_shigh[i];
                m_pend[i] = 1'b0;
            end
        end
        if (v) begin
            $display("cfg ch=%0d div=%0d high=%0d ready=%0b", ch, d, h, ready_exp);
            if (ready_exp && ch < NUM_CH) begin
                m_sdiv[ch]  = d;
                m_shigh[ch] = h;
                m_pend[ch]  = 1'b1;
            end
        end
        ecount++;
        #1;
    endtask

    // Idle (no config) until the model shows nothing pending; bounded.
    task automatic wait_idle(input logic [NUM_CH-1:0] en);
        for (int k = 0; k < 40; k++) begin
            if (pend_vec() == '0) break;
            step(en, 1'b0, 1'b0, 0, 0, 0);
        end
    endtask

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (clock_out !== '0) begin
            errors++; $display("FAIL reset clock_out got=%b exp=%b", clock_out, {NUM_CH{1'b0}});
        end
        checks++;
        if (cfg_pending !== '0) begin
            errors++; $display("FAIL reset cfg_pending got=%b exp=%b", cfg_pending, {NUM_CH{1'b0}});
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL reset cfg_ready got=%b exp=1", cfg_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_default_period();
        int highs;
        highs = 0;
        for (int k = 0; k < 30; k++) begin
            step('1, 1'b0, 1'b0, 0, 0, 0);
            if (k == 0) begin
                checks++;
                if (clock_out !== '1) begin
                    errors++; $display("FAIL first_high clock_out got=%b exp=%b", clock_out, {NUM_CH{1'b1}});
                end
            end
            if (k >= 1 && k <= 20) highs += int'(clock_out[0]);
            checks++;
            if (clock_out !== out_vec()) begin
                errors++; $display("FAIL default clock_out k=%0d got=%b exp=%b", k, clock_out, out_vec());
            end
`ifdef CLKDIV_TICK_EN
            checks++;
            if (tick !== tick_vec()) begin
                errors++; $display("FAIL default tick k=%0d got=%b exp=%b", k, tick, tick_vec());
            end
`endif
        end
        checks++;
        if (highs != 10) begin
            errors++; $display("FAIL default duty highs got=%0d exp=10", highs);
        end
    endtask

    task automatic test_runtime_change();
        int highs;
        wait_idle('1);
        step('1, 1'b0, 1'b0, 0, 0, 0);
        step('1, 1'b0, 1'b1, 1, 6, 2);
        checks++;
        if (cfg_pending[1] !== 1'b1) begin
            errors++; $display("FAIL change pending1 got=%b exp=1", cfg_pending[1]);
        end
        step('1, 1'b0, 1'b1, 1, 9, 9);
        checks++;
        if (ready_seen !== 1'b0) begin
            errors++; $display("FAIL change ready_blocked got=%b exp=0", ready_seen);
        end
        step('1, 1'b0, 1'b1, 2, 10, 5);
        checks++;
        if (ready_seen !== 1'b1) begin
            errors++; $display("FAIL change ready_ch2 got=%b exp=1", ready_seen);
        end
        highs = 0;
        for (int k = 0; k < 40; k++) begin
            step('1, 1'b0, 1'b0, 0, 0, 0);
            if (k >= 28) highs += int'(clock_out[1]);
            checks++;
            if (clock_out !== out_vec() || cfg_pending !== pend_vec()) begin
                errors++; $display("FAIL change k=%0d out got=%b exp=%b pend got=%b exp=%b",
                                   k, clock_out, out_vec(), cfg_pending, pend_vec());
            end
        end
        checks++;
        if (highs != 4) begin
            errors++; $display("FAIL change ch1 highs in 12 got=%0d exp=4", highs);
        end
    endtask

    task automatic test_boundaries();
        int h0, h1, h2, h3;
        wait_idle('1);
        step('1, 1'b0, 1'b1, 0, 1, 1);
        step('1, 1'b0, 1'b1, 1, 10, 0);
        step('1, 1'b0, 1'b1, 2, 8, 20);
        step('1, 1'b0, 1'b1, 7, 3, 1);
        checks++;
        if (ready_seen !== 1'b1 || cfg_pending[3] !== 1'b0) begin
            errors++; $display("FAIL bound ch7 ready got=%b exp=1 pend3 got=%b exp=0", ready_seen, cfg_pending[3]);
        end
        h0 = 0; h1 = 0; h2 = 0; h3 = 0;
        for (int k = 0; k < 40; k++) begin
            step('1, 1'b0, 1'b0, 0, 0, 0);
            if (k >= 30) begin
                h0 += int'(clock_out[0]); h1 += int'(clock_out[1]);
                h2 += int'(clock_out[2]); h3 += int'(clock_out[3]);
            end
            checks++;
            if (clock_out !== out_vec() || cfg_pending !== pend_vec()) begin
                errors++; $display("FAIL bound k=%0d out got=%b exp=%b pend got=%b exp=%b",
                                   k, clock_out, out_vec(), cfg_pending, pend_vec());
            end
        end
        checks++;
        if (h0 != 5 || h1 != 0 || h2 != 10 || h3 != 5) begin
            errors++; $display("FAIL bound highs got=%0d,%0d,%0d,%0d exp=5,0,10,5", h0, h1, h2, h3);
        end
    endtask

    task automatic test_sync();
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] prev;
        int both, first, n;
        en = 4'b1011;
        wait_idle(en);
        step(en, 1'b0, 1'b1, 0, 4, 2);
        step(en, 1'b0, 1'b1, 1, 6, 3);
        n = $urandom_range(3, 15);
        for (int k = 0; k < n; k++) step(en, 1'b0, 1'b0, 0, 0, 0);
        step(en, 1'b1, 1'b0, 0, 0, 0);
        checks++;
        if (clock_out !== out_vec() || clock_out[2] !== 1'b0 || cfg_pending !== '0) begin
            errors++; $display("FAIL sync edge out got=%b exp=%b pend got=%b exp=0",
                               clock_out, out_vec(), cfg_pending);
        end
        prev = clock_out;
        both = 0; first = -1;
        for (int k = 1; k <= 26; k++) begin
            step(en, 1'b0, 1'b0, 0, 0, 0);
            if (clock_out[0] && !prev[0] && clock_out[1] && !prev[1]) begin
                both++;
                if (first < 0) first = k;
            end
            prev = clock_out;
            checks++;
            if (clock_out !== out_vec()) begin
                errors++; $display("FAIL sync k=%0d clock_out got=%b exp=%b", k, clock_out, out_vec());
            end
        end
        checks++;
        if (both != 2 || first != 13) begin
            errors++; $display("FAIL sync coincident rises got=%0d first=%0d exp=2 first=13", both, first);
        end
    endtask

    task automatic test_reset_mid();
        int highs;
        wait_idle('1);
        step('1, 1'b0, 1'b1, 0, 4, 1);
        checks++;
        if (cfg_pending[0] !== 1'b1) begin
            errors++; $display("FAIL rstmid pending before got=%b exp=1", cfg_pending[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (clock_out !== '0 || cfg_pending !== '0) begin
            errors++; $display("FAIL rstmid async clear out got=%b pend got=%b exp=0", clock_out, cfg_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        highs = 0;
        for (int k = 0; k < 25; k++) begin
            step('1, 1'b0, 1'b0, 0, 0, 0);
            if (k >= 1 && k <= 20) highs += int'(clock_out[0]);
            checks++;
            if (clock_out !== out_vec() || cfg_pending !== pend_vec()) begin
                errors++; $display("FAIL rstmid k=%0d out got=%b exp=%b pend got=%b exp=%b",
                                   k, clock_out, out_vec(), cfg_pending, pend_vec());
            end
        end
        checks++;
        if (highs != 10) begin
            errors++; $display("FAIL rstmid ch0 highs got=%0d exp=10", highs);
        end
    endtask

    task automatic test_random();
        logic [NUM_CH-1:0] en;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 9) != 0);
            step(en, ($urandom_range(0, 29) == 0), ($urandom_range(0, 2) == 0),
                 $urandom_range(0, 7), $urandom_range(0, 12), $urandom_range(0, 14));
            checks++;
            if (ready_seen !== ready_exp) begin
                errors++; $display("FAIL random k=%0d cfg_ready got=%b exp=%b", k, ready_seen, ready_exp);
            end
            checks++;
            if (clock_out !== out_vec() || cfg_pending !== pend_vec()) begin
                errors++; $display("FAIL random k=%0d out got=%b exp=%b pend got=%b exp=%b",
                                   k, clock_out, out_vec(), cfg_pending, pend_vec());
            end
`ifdef CLKDIV_TICK_EN
            checks++;
            if (tick !== tick_vec()) begin
                errors++; $display("FAIL random k=%0d tick got=%b exp=%b", k, tick, tick_vec());
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_runtime_change();
        test_boundaries();
        test_sync();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel, runtime-programmable successor to the fixed single-output divider.
- Generates NUM_CH divided clock-enable-style square waves from one fabric clock. Each channel has its own divisor and high-time.
- Divisor and high-time updates are accepted through a valid/ready config port and applied glitch-free at the channel's period boundary.
- A shared sync input phase-aligns all channels. Drives ADC sample-clock and test-pattern timing in the LVDS capture path.

Parameters:
- NUM_CH, 4, number of output channels (1..16).
- CNT_W, 28, counter/divisor/high-time width in bits.
- DEF_DIV, 50_000_000, divisor loaded into every channel at reset.
- CH_W, 2, width of cfg_ch; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clock_in  input  1  fabric clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- ch_en  input  NUM_CH  per-channel run enable.
- sync  input  1  single-cycle pulse; restarts all enabled channels at phase 0.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  config request can be accepted.
- cfg_ch  input  CH_W  target channel index.
- cfg_div  input  CNT_W  new divisor (period in clock_in cycles).
- cfg_high  input  CNT_W  new high-time in clock_in cycles.
- clock_out  output  NUM_CH  divided outputs, registered.
- cfg_pending  output  NUM_CH  shadow config waiting for boundary.

Behaviour:
- Reset (async, reset_n=0), every channel:
  - cnt=0
  - div_act=DEF_DIV, high_act=DEF_DIV/2
  - shadow regs = active values
  - pending=0
  - clock_out=0
- Effective divisor: eff_div = max(div_act, 2). cfg_div values 0 and 1 behave as 2.
- Enabled channel, each edge:
  - Counter: cnt <= (cnt >= eff_div-1) ? 0 : cnt+1.
  - Output: clock_out[i] <= (cnt < high_act), evaluated on pre-update cnt. This gives one-cycle latency from counter to pin.
- high_act=0 gives a constant-low output. high_act >= eff_div gives a constant-high output.
- Wrap cycle (cnt >= eff_div-1): if pending, div_act <= div_sh, high_act <= high_sh, pending <= 0. New values govern the next period starting at cnt=0.
- Config handshake:
  - cfg_ready = !pending[cfg_ch], combinational.
  - Transfer occurs on cfg_valid && cfg_ready. It writes div_sh/high_sh and sets pending.
  - cfg_ch >= NUM_CH: cfg_ready=1, transfer dropped, no state change.
- Transfer on the same cycle as that channel's wrap: values go to shadow and are applied at the following wrap, never the current one.
- Disabled channel (ch_en[i]=0):
  - cnt held at 0 and clock_out[i] <= 0.
  - Any pending shadow is applied on the next edge, so a disabled channel never blocks cfg_ready for more than one cycle.
- Enable rising: counting starts from cnt=0. The first output-high cycle is the edge after enable.
- sync=1, enabled channels:
  - cnt <= 0.
  - Pending shadow applied immediately.
  - clock_out[i] <= (0 < high_act_new).
- sync and ch_en=0 on the same cycle: disable wins.
- Mid-operation reset: asynchronous clear to reset values. Any pending config is lost.

Optional Feature:
- Macro: CLKDIV_TICK_EN.
- Defined:
  - Adds output port tick[NUM_CH].
  - tick[i] is a one-cycle registered pulse on the edge where channel i's counter wraps to 0, and also on sync restart.
  - Reset value 0. Always 0 when the channel is disabled.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package clkdiv_pkg holds:
  - constant DEF_DIV_C
  - typedef cnt_t (logic [CNT_W-1:0])
  - typedef ch_cfg_t (struct: div, high)
  - function eff_div() implementing the clamp-to-2 rule
- Sub-module clkdiv_channel: one counter, active/shadow registers, pending flag, output register (and tick under CLKDIV_TICK_EN).
- Top instantiates NUM_CH channels with a generate loop. Top also decodes cfg_ch into per-channel write strobes and muxes cfg_ready.

Test Plan:
- Reset release, DEF_DIV overridden to 10 → every enabled clock_out has period 10 and is high 5 cycles. First high edge is one cycle after ch_en rises.
- Runtime change on ch1: div=10 → cfg div=6, high=2 mid-period → current period completes at 10 cycles, then period 6 with high 2. No runt pulse; cfg_pending[1] clears on the wrap edge.
- Second cfg to ch1 while pending → cfg_ready=0 until the wrap. A cfg to ch2 in the same window is accepted with cfg_ready=1.
- Boundaries:
  - cfg div=1, high=1 → period 2, 50% duty.
  - high=0 → output stuck low.
  - high=20, div=8 → output stuck high.
  - cfg_ch=7 with NUM_CH=4 → accepted, no effect.
- Sync with ch0 div=4 and ch1 div=6 at arbitrary phases → both restart at cnt=0 on the same edge, and both rising edges coincide every 12 cycles. A channel with ch_en=0 on the sync cycle stays low.
- Assert reset_n mid-period with a pending config → clock_out=0 immediately, pending lost. After release, period is DEF_DIV. With CLKDIV_TICK_EN, tick pulses once per wrap only.
